adc_avg_dir: RTL and testbench

Downstream consumer of the two-channel ADC controller's packed 16-bit output word, with channel 1 in bits [15:8] and channel 0 in bits [7:0]. It samples that word at a fixed rate and rejects captures taken while the word is mid-update. It box-car averages each channel over 2^AVG_LOG2 samples, then drives a hysteretic three-way direction decision (toward ch0 / centered / toward ch1) for the robot's tracking logic.

---
 rtl/adc_avg_dir_pkg.sv | 20 ++
 rtl/adc_chan_avg.sv | 54 +++++
 rtl/adc_avg_dir.sv | 153 +++++++++++++++
 tb/tb_adc_avg_dir.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/adc_avg_dir_pkg.sv
// Shared definitions for the ADC averaging / direction block: packed-word
// channel layout, direction encodings and capture FSM states.
package adc_avg_dir_pkg;

    localparam int CH_W    = 8;
    localparam int CH0_LSB = 0;
    localparam int CH1_LSB = 8;

    typedef enum logic [1:0] {
        DIR_CENTER = 2'b00,
        DIR_CH0    = 2'b01,
        DIR_CH1    = 2'b10
    } dir_e;

    typedef enum logic {
        CAP_WAIT = 1'b0,
        CAP_PEND = 1'b1
    } cap_state_e;

endpackage

// File: rtl/adc_chan_avg.sv
// One channel of the box-car averager: accumulates accepted samples and
// publishes the truncated mean when the shared counter marks the last sample.
module adc_chan_avg
    import adc_avg_dir_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            i_accept,
    input  logic [CH_W-1:0] i_sample,
    input  logic            i_clear,
    output logic [CH_W-1:0] o_avg,
    output logic            o_done
);

    localparam int ACC_W = CH_W + AVG_LOG2;

    logic [ACC_W-1:0] r_acc_p0;
    logic [ACC_W-1:0] w_sum_p0;
    logic [CH_W-1:0]  r_avg_p1;
    logic             r_vld_p1;

    function automatic logic [CH_W-1:0] trunc_avg(input logic [ACC_W-1:0] sum);
        return sum[ACC_W-1:AVG_LOG2];
    endfunction

    // The completing sample is folded in before the shift.
    assign w_sum_p0 = r_acc_p0 + ACC_W'(i_sample);

    // Stage p0 -> p1: accumulate, or publish the mean and restart.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_acc_p0 <= '0;
            r_avg_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= 1'b0;
            if (i_accept) begin
                if (i_clear) begin
                    r_avg_p1 <= trunc_avg(w_sum_p0);
                    r_acc_p0 <= '0;
                    r_vld_p1 <= 1'b1;
                end else begin
                    r_acc_p0 <= w_sum_p0;
                end
            end
        end
    end

    assign o_avg  = r_avg_p1;
    assign o_done = r_vld_p1;

endmodule

// File: rtl/adc_avg_dir.sv
// Samples the packed two-channel ADC word at a fixed rate, skipping captures
// taken mid-update, averages both channels and drives a hysteretic direction.
module adc_avg_dir
    import adc_avg_dir_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int AVG_LOG2   = 3,
    parameter int TH_ON      = 16,
    parameter int TH_OFF     = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [15:0] iDATA,
    output logic [7:0]  oCH0_AVG,
    output logic [7:0]  oCH1_AVG,
    output logic        oVALID,
    output logic [1:0]  oDIR
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    localparam logic signed [8:0] TH_ON_P  = 9'(TH_ON);
    localparam logic signed [8:0] TH_ON_N  = 9'(-TH_ON);
    localparam logic signed [8:0] TH_OFF_P = 9'(TH_OFF);
    localparam logic signed [8:0] TH_OFF_N = 9'(-TH_OFF);

    logic [15:0]         r_d1_p0;
    logic [15:0]         r_d2_p1;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic                w_tick;
    cap_state_e          r_cap_state;
    cap_state_e          w_cap_next;
    logic                w_accept;
    logic [AVG_LOG2-1:0] r_n;
    logic                w_last;
    logic [CH_W-1:0]     w_avg0;
    logic [CH_W-1:0]     w_avg1;
    logic                w_done0;
    logic                w_done1;
    logic                w_vld_p2;
    logic signed [8:0]   w_diff_p2;
    dir_e                r_dir_p3;

    function automatic dir_e dir_next(input dir_e cur, input logic signed [8:0] diff);
        dir_e nxt;
        nxt = cur;
        case (cur)
            DIR_CH1: begin
                if (diff < TH_ON_N)       nxt = DIR_CH0;
                else if (diff < TH_OFF_P) nxt = DIR_CENTER;
            end
            DIR_CH0: begin
                if (diff > TH_ON_P)       nxt = DIR_CH1;
                else if (diff > TH_OFF_N) nxt = DIR_CENTER;
            end
            default: begin
                if (diff > TH_ON_P)      nxt = DIR_CH1;
                else if (diff < TH_ON_N) nxt = DIR_CH0;
                else                     nxt = DIR_CENTER;
            end
        endcase
        return nxt;
    endfunction

    // Stage p0/p1: two-deep input history used to detect a word mid-update.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_d1_p0 <= '0;
            r_d2_p1 <= '0;
        end else begin
            r_d1_p0 <= iDATA;
            r_d2_p1 <= r_d1_p0;
        end
    end

    assign w_tick = (r_tick_cnt == CNT_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_tick_cnt  <= '0;
            r_cap_state <= CAP_WAIT;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_cap_state <= w_cap_next;
        end
    end

    // Ticks arriving while PEND are dropped: at most one capture outstanding.
    always_comb begin
        w_cap_next = r_cap_state;
        w_accept   = 1'b0;
        case (r_cap_state)
            CAP_WAIT: if (w_tick) w_cap_next = CAP_PEND;
            CAP_PEND: begin
                if (r_d1_p0 == r_d2_p1) begin
                    w_accept   = 1'b1;
                    w_cap_next = CAP_WAIT;
                end
            end
            default: w_cap_next = CAP_WAIT;
        endcase
    end

    assign w_last = &r_n;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_n <= '0;
        end else if (w_accept) begin
            r_n <= w_last ? '0 : r_n + 1'b1;
        end
    end

    // Stage p1 -> p2: per-channel accumulation and averaging.
    adc_chan_avg #(.AVG_LOG2(AVG_LOG2)) u_ch0 (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .i_accept (w_accept),
        .i_sample (r_d2_p1[CH0_LSB +: CH_W]),
        .i_clear  (w_last),
        .o_avg    (w_avg0),
        .o_done   (w_done0)
    );

    adc_chan_avg #(.AVG_LOG2(AVG_LOG2)) u_ch1 (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .i_accept (w_accept),
        .i_sample (r_d2_p1[CH1_LSB +: CH_W]),
        .i_clear  (w_last),
        .o_avg    (w_avg1),
        .o_done   (w_done1)
    );

    assign w_vld_p2  = w_done0 & w_done1;
    assign w_diff_p2 = $signed({1'b0, w_avg1}) - $signed({1'b0, w_avg0});

    // Stage p2 -> p3: direction follows each freshly published average pair.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_dir_p3 <= DIR_CENTER;
        end else if (w_vld_p2) begin
            r_dir_p3 <= dir_next(r_dir_p3, w_diff_p2);
        end
    end

    assign oCH0_AVG = w_avg0;
    assign oCH1_AVG = w_avg1;
    assign oVALID   = w_vld_p2;
    assign oDIR     = r_dir_p3;

endmodule

// File: tb/tb_adc_avg_dir.sv
// Self-checking bench for adc_avg_dir: vector table of block averages plus
// hand-built sequences for capture rejection and mid-block reset.
module tb_adc_avg_dir;

    logic        iCLK;
    logic        iRST;
    logic [15:0] iDATA;
    logic [7:0]  oCH0_AVG;
    logic [7:0]  oCH1_AVG;
    logic        oVALID;
    logic [1:0]  oDIR;

    adc_avg_dir #(
        .SAMPLE_DIV (4),
        .AVG_LOG2   (2),
        .TH_ON      (16),
        .TH_OFF     (8)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iDATA    (iDATA),
        .oCH0_AVG (oCH0_AVG),
        .oCH1_AVG (oCH1_AVG),
        .oVALID   (oVALID),
        .oDIR     (oDIR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  ch0;
        logic [7:0]  ch1;
        logic [1:0]  dir;
    } vec_t;

    typedef struct {
        logic [7:0] ch0;
        logic [7:0] ch1;
        logic [1:0] dir;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_valid(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge iCLK);
            cycles++;
        end while (oVALID !== 1'b1 && cycles < bound);
        if (oVALID !== 1'b1) begin
            n_total++;
            $display("FAIL valid_timeout: got no oVALID expected one within %0d cycles", bound);
        end
    endtask

    // Scoreboard consumer: averages at the pulse, direction one cycle later.
    initial begin : monitor
        logic       prev_vld;
        logic       dir_pend;
        logic [1:0] dir_exp;
        logic [1:0] last_dir;
        exp_t       e;
        prev_vld = 1'b0;
        dir_pend = 1'b0;
        dir_exp  = 2'b00;
        last_dir = 2'b00;
        forever begin
            @(negedge iCLK);
            if (dir_pend) begin
                check("dir_after_valid", oDIR, dir_exp);
                last_dir = dir_exp;
                dir_pend = 1'b0;
            end
            if (prev_vld) check("valid_one_cycle", oVALID, 1'b0);
            if (oVALID === 1'b1 && !prev_vld) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got oVALID=1 ch0=%h ch1=%h expected no pulse", oCH0_AVG, oCH1_AVG);
                end else begin
                    e = sb.pop_front();
                    check("ch0_avg", oCH0_AVG, e.ch0);
                    check("ch1_avg", oCH1_AVG, e.ch1);
                    check("dir_hold_at_valid", oDIR, last_dir);
                    dir_pend = 1'b1;
                    dir_exp  = e.dir;
                end
            end
            prev_vld = (oVALID === 1'b1);
        end
    end

    initial begin : main
        int cyc;
        vecs[0] = '{16'h8040, 8'h40, 8'h80, 2'b10};
        vecs[1] = '{16'h4C40, 8'h40, 8'h4C, 2'b10};
        vecs[2] = '{16'h4740, 8'h40, 8'h47, 2'b00};
        vecs[3] = '{16'h2C40, 8'h40, 8'h2C, 2'b01};
        vecs[4] = '{16'h5440, 8'h40, 8'h54, 2'b10};
        vecs[5] = '{16'h4040, 8'h40, 8'h40, 2'b00};
        vecs[6] = '{16'hFFFF, 8'hFF, 8'hFF, 2'b00};

        iRST  = 1'b1;
        iDATA = 16'h8040;
        @(posedge iCLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("rst_ch0", oCH0_AVG, 8'h00);
            check("rst_ch1", oCH1_AVG, 8'h00);
            check("rst_valid", oVALID, 1'b0);
            check("rst_dir", oDIR, 2'b00);
            if (i == 2) iRST = 1'b0;
        end
        @(negedge iCLK);
        check("post_rst_ch0", oCH0_AVG, 8'h00);
        check("post_rst_ch1", oCH1_AVG, 8'h00);
        check("post_rst_valid", oVALID, 1'b0);
        check("post_rst_dir", oDIR, 2'b00);

        for (int i = 0; i < 7; i++) begin
            iDATA = vecs[i].data;
            sb.push_back('{vecs[i].ch0, vecs[i].ch1, vecs[i].dir});
            wait_valid(100, cyc);
            check("block_latency", cyc, (i == 0) ? 16 : 15);
            @(negedge iCLK);
        end

        // Toggle across several ticks, then settle: one accept after settling.
        for (int i = 0; i < 16; i++) begin
            iDATA = (i % 2 == 0) ? 16'h1234 : 16'h5678;
            @(negedge iCLK);
        end
        iDATA = 16'h2030;
        sb.push_back('{8'h30, 8'h20, 2'b00});
        wait_valid(60, cyc);
        check("settle_latency", cyc, 15);

        // Two accepts of 0xF0F0, then reset: those samples must vanish.
        iDATA = 16'hF0F0;
        repeat (8) @(negedge iCLK);
        iRST  = 1'b1;
        iDATA = 16'h1010;
        @(negedge iCLK);
        check("midrst_ch0", oCH0_AVG, 8'h00);
        check("midrst_valid", oVALID, 1'b0);
        @(negedge iCLK);
        check("midrst_dir", oDIR, 2'b00);
        iRST = 1'b0;
        sb.push_back('{8'h10, 8'h10, 2'b00});
        wait_valid(100, cyc);
        check("midrst_latency", cyc, 17);
        repeat (3) @(negedge iCLK);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
